operand2_imm_encoder: RTL and testbench
=======================================

Name: operand2_imm_encoder

Overview:
- Iterative encoder for data-processing immediates: the inverse of the operand-2 rotate decode.
- Takes a 32-bit constant and searches for rot (0..15) and imm8 such that ROR(imm8, 2*rot) equals the constant, or its bitwise inverse when inversion is enabled.
- Used by the assembler/test-vector path and the instruction-build logic to produce IR[11:0] for `001` data-processing instructions.
- Tests one rotation per clock, with valid/ready handshakes on both ends.

Parameters:
- ENABLE_INVERT, 1, when 1 also tests ~value in each cycle; the result is flagged so the caller can swap MOV/MVN or AND/BIC.
- EARLY_EXIT, 1, when 1 finishes on the first hit; when 0 always runs all 16 rotations, giving constant latency, and still reports the first hit.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept; high only in IDLE
- in_value  in  32  constant to encode
- out_valid  out  1  result valid; held until consumed
- out_ready  in  1  consumer accepts result
- out_encodable  out  1  1 = encoding found
- out_inverted  out  1  1 = encoding is of ~in_value
- out_imm12  out  12  {rot[3:0], imm8[7:0]}; 0 when not encodable
- out_cycles  out  5  rotations tested (1..16), for debug/perf

Behaviour:
- Reset value of every output:
  - Asserting rst_n low clears all outputs to 0, except in_ready = 0 while reset is asserted.
  - in_ready goes to 1 on the first edge after rst_n is released (IDLE).
  - Reset mid-search abandons the search; no result is produced.
- States:
  - IDLE: in_ready = 1.
  - SEARCH: in_ready = 0, out_valid = 0.
  - DONE: out_valid = 1.
- Accept: in_valid && in_ready at edge E0 latches in_value into val_q, sets k = 0, and moves to SEARCH.
- Per-cycle test in SEARCH with index k:
  - Compute p = ROL(val_q, 2k) and n = ROL(~val_q, 2k).
  - Plain hit: p[31:8] == 0.
  - Inverted hit: n[31:8] == 0 and ENABLE_INVERT == 1.
- Priority: lowest k wins; at equal k, plain beats inverted.
  - Example: 0xFFFFFF00 gives inverted at k = 0.
- On a hit (EARLY_EXIT = 1):
  - At edge E0+k+1, register out_imm12 = {k, p[7:0] or n[7:0]}, out_encodable = 1, out_inverted = 1 if the inverted hit won, out_cycles = k+1.
  - Move to DONE.
- Miss at k = 15: register out_encodable = 0, out_imm12 = 0, out_cycles = 16, and go to DONE at E0+16.
- EARLY_EXIT = 0:
  - The first hit is stored in a sticky register; later hits are ignored.
  - Transition to DONE always occurs at E0+16; out_cycles = 16.
- DONE: outputs are stable while out_ready = 0. out_valid && out_ready returns to IDLE on that edge and clears out_valid.
  - No bypass: a new request is accepted at the earliest one cycle after the return to IDLE.
- in_valid while busy is ignored; the requester must hold it until in_ready.
- in_value changing during SEARCH has no effect (val_q is used).
- k is a 4-bit counter; no wrap beyond 15, since SEARCH exits at 15.
- Value 0 encodes as rot 0, imm8 0, not inverted.

Decomposition:
- Shared package `cpu_pkg` holds:
  - ROT_STEPS = 16
  - IMM8_W = 8
  - the state enum {IDLE, SEARCH, DONE}
  - the shift-type constants LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11, shared with the shifter.
- One natural sub-module: `rotl32`, a combinational 32-bit rotate-left by a 5-bit amount.
  - Instantiated twice, for the plain and inverted paths.

Test Plan:
- 0x000000FF -> out_valid 1 cycle after accept; imm12 = 0x0FF, encodable = 1, inverted = 0, cycles = 1.
- 0xFF000000 -> imm12 = 0x4FF, cycles = 5. 0xF000000F (wrap-around) -> imm12 = 0x2FF, cycles = 3.
- 0x000003FC -> imm12 = 0xFFF (rot 15), cycles = 16. 0x00000101 -> encodable = 0, imm12 = 0, cycles = 16.
- 0xFFFFFF00 -> imm12 = 0x0FF, inverted = 1. Repeat with ENABLE_INVERT = 0 -> encodable = 0. Repeat with EARLY_EXIT = 0 on 0x000000FF -> out_valid at E0+16, imm12 = 0x0FF.
- Hold out_ready = 0 for 5 cycles in DONE -> outputs stable and in_ready = 0; assert out_ready -> IDLE next edge, then a back-to-back second request completes.
- Pulse rst_n low during SEARCH of 0x00000101 -> outputs 0 immediately, no out_valid; the next request 0x0 gives imm12 = 0x000, cycles = 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand-2 rotation geometry, encoder FSM states and
// the shift-type codes used by the barrel shifter.
package cpu_pkg;

    localparam int unsigned ROT_STEPS = 16;
    localparam int unsigned IMM8_W    = 8;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_e;

endpackage

// File: rtl/rotl32.sv
// Combinational 32-bit rotate-left by a 5-bit amount.
module rotl32 (
    input  logic [31:0] data_i,
    input  logic [4:0]  amt_i,
    output logic [31:0] data_o
);

    // A shift by 32 yields zero, so amt_i == 0 leaves data_i untouched.
    assign data_o = (data_i << amt_i) | (data_i >> (6'd32 - {1'b0, amt_i}));

endmodule

// File: rtl/operand2_imm_encoder.sv
// Iterative operand-2 immediate encoder: finds {rot, imm8} with
// ROR(imm8, 2*rot) == value (or ~value), testing one rotation per clock.
module operand2_imm_encoder
    import cpu_pkg::*;
#(
    parameter bit ENABLE_INVERT = 1'b1,
    parameter bit EARLY_EXIT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_encodable,
    output logic        out_inverted,
    output logic [11:0] out_imm12,
    output logic [4:0]  out_cycles
);

    localparam int unsigned KW = $clog2(ROT_STEPS);
    localparam logic [KW-1:0] KLast = KW'(ROT_STEPS - 1);

    state_e        state_q, state_d;
    logic [31:0]   val_q, val_d;
    logic [KW-1:0] k_q, k_d;
    logic          ready_q, ready_d;
    logic          found_q, found_d;
    logic          hold_inv_q, hold_inv_d;
    logic [11:0]   hold_imm_q, hold_imm_d;
    logic          enc_q, enc_d;
    logic          inv_q, inv_d;
    logic [11:0]   imm_q, imm_d;
    logic [4:0]    cyc_q, cyc_d;

    logic [31:0] p_rot, n_rot;
    logic        plain_hit, inv_hit, hit;
    logic [11:0] cur_imm;

    rotl32 u_rot_plain (
        .data_i (val_q),
        .amt_i  ({k_q, 1'b0}),
        .data_o (p_rot)
    );

    rotl32 u_rot_inv (
        .data_i (~val_q),
        .amt_i  ({k_q, 1'b0}),
        .data_o (n_rot)
    );

    assign plain_hit = (p_rot[31:IMM8_W] == '0);
    assign inv_hit   = ENABLE_INVERT && (n_rot[31:IMM8_W] == '0);
    assign hit       = plain_hit | inv_hit;
    // Plain wins over inverted at the same rotation.
    assign cur_imm   = {k_q, plain_hit ? p_rot[IMM8_W-1:0] : n_rot[IMM8_W-1:0]};

    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        k_d        = k_q;
        found_d    = found_q;
        hold_inv_d = hold_inv_q;
        hold_imm_d = hold_imm_q;
        enc_d      = enc_q;
        inv_d      = inv_q;
        imm_d      = imm_q;
        cyc_d      = cyc_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    val_d   = in_value;
                    k_d     = '0;
                    found_d = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                // Sticky first hit; only consulted when the search runs to the end.
                if (hit && !found_q) begin
                    found_d    = 1'b1;
                    hold_imm_d = cur_imm;
                    hold_inv_d = !plain_hit;
                end
                if ((EARLY_EXIT && hit) || (k_q == KLast)) begin
                    state_d = DONE;
                    enc_d   = found_q | hit;
                    inv_d   = found_q ? hold_inv_q : (hit && !plain_hit);
                    imm_d   = found_q ? hold_imm_q : (hit ? cur_imm : 12'h000);
                    cyc_d   = {1'b0, k_q} + 5'd1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            val_q      <= '0;
            k_q        <= '0;
            ready_q    <= 1'b0;
            found_q    <= 1'b0;
            hold_inv_q <= 1'b0;
            hold_imm_q <= '0;
            enc_q      <= 1'b0;
            inv_q      <= 1'b0;
            imm_q      <= '0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            val_q      <= val_d;
            k_q        <= k_d;
            ready_q    <= ready_d;
            found_q    <= found_d;
            hold_inv_q <= hold_inv_d;
            hold_imm_q <= hold_imm_d;
            enc_q      <= enc_d;
            inv_q      <= inv_d;
            imm_q      <= imm_d;
            cyc_q      <= cyc_d;
        end
    end

    assign in_ready      = ready_q;
    assign out_valid     = (state_q == DONE);
    assign out_encodable = enc_q;
    assign out_inverted  = inv_q;
    assign out_imm12     = imm_q;
    assign out_cycles    = cyc_q;

endmodule

// File: tb/tb_operand2_imm_encoder.sv
// Scoreboard bench for operand2_imm_encoder: three instances cover the default,
// no-inversion and constant-latency configurations.
module tb_operand2_imm_encoder;

    typedef struct {
        logic        enc;
        logic        inv;
        logic [11:0] imm;
        logic [4:0]  cyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  in_valid, in_ready, out_valid, out_ready, out_enc, out_inv;
    logic [31:0] in_value [3];
    logic [11:0] out_imm [3];
    logic [4:0]  out_cyc [3];

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    operand2_imm_encoder #(.ENABLE_INVERT(1'b1), .EARLY_EXIT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_value(in_value[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_encodable(out_enc[0]), .out_inverted(out_inv[0]), .out_imm12(out_imm[0]),
        .out_cycles(out_cyc[0])
    );

    operand2_imm_encoder #(.ENABLE_INVERT(1'b0), .EARLY_EXIT(1'b1)) u_noinv (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_value(in_value[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_encodable(out_enc[1]), .out_inverted(out_inv[1]), .out_imm12(out_imm[1]),
        .out_cycles(out_cyc[1])
    );

    operand2_imm_encoder #(.ENABLE_INVERT(1'b1), .EARLY_EXIT(1'b0)) u_late (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_value(in_value[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_encodable(out_enc[2]), .out_inverted(out_inv[2]), .out_imm12(out_imm[2]),
        .out_cycles(out_cyc[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic enc, input logic inv, input logic [11:0] imm,
                                input logic [4:0] cyc, input int lat);
        exp_t e;
        e.enc = enc;
        e.inv = inv;
        e.imm = imm;
        e.cyc = cyc;
        e.lat = lat;
        return e;
    endfunction

    task automatic check_out(input int d, input exp_t e);
        check_eq("encodable", 32'(out_enc[d]), 32'(e.enc));
        check_eq("inverted", 32'(out_inv[d]), 32'(e.inv));
        check_eq("imm12", 32'(out_imm[d]), 32'(e.imm));
        check_eq("cycles", 32'(out_cyc[d]), 32'(e.cyc));
    endtask

    // Starts and ends on a falling edge; the accept happens on the rising edge between.
    task automatic issue(input int d, input logic [31:0] value, input exp_t e, input bit push);
        int guard = 0;
        while (!in_ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready[d]) check_eq("ready_timeout", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        in_value[d] = value;
        if (push) sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_value[d] = ~value;  // must not disturb the search
    endtask

    task automatic collect(input int d, input int hold);
        exp_t e;
        int   lat = 0;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("busy_ready", 32'(in_ready[d]), 32'd0);
        while (!out_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(e.lat));
        check_out(d, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid[d]), 32'd1);
            check_eq("hold_ready", 32'(in_ready[d]), 32'd0);
            check_out(d, e);
        end
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
        check_eq("drain_valid", 32'(out_valid[d]), 32'd0);
        check_eq("drain_ready", 32'(in_ready[d]), 32'd1);
    endtask

    task automatic run(input int d, input logic [31:0] value, input exp_t e);
        issue(d, value, e, 1'b1);
        collect(d, 0);
    endtask

    initial begin
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) in_value[i] = '0;

        #2;
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_imm", 32'(out_imm[0]), 32'd0);
        @(negedge clk);
        check_eq("rst_ready_held", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(in_ready), 32'h7);

        run(0, 32'h0000_00FF, mk(1'b1, 1'b0, 12'h0FF, 5'd1, 1));
        run(0, 32'hFF00_0000, mk(1'b1, 1'b0, 12'h4FF, 5'd5, 5));
        run(0, 32'hF000_000F, mk(1'b1, 1'b0, 12'h2FF, 5'd3, 3));
        run(0, 32'h0000_03FC, mk(1'b1, 1'b0, 12'hFFF, 5'd16, 16));
        run(0, 32'h0000_0101, mk(1'b0, 1'b0, 12'h000, 5'd16, 16));
        run(0, 32'hFFFF_FF00, mk(1'b1, 1'b1, 12'h0FF, 5'd1, 1));

        run(1, 32'hFFFF_FF00, mk(1'b0, 1'b0, 12'h000, 5'd16, 16));
        run(1, 32'h0000_00FF, mk(1'b1, 1'b0, 12'h0FF, 5'd1, 1));

        run(2, 32'h0000_00FF, mk(1'b1, 1'b0, 12'h0FF, 5'd16, 16));
        run(2, 32'h0000_0003, mk(1'b1, 1'b0, 12'h003, 5'd16, 16));
        run(2, 32'h0000_03FC, mk(1'b1, 1'b0, 12'hFFF, 5'd16, 16));
        run(2, 32'hFFFF_FF00, mk(1'b1, 1'b1, 12'h0FF, 5'd16, 16));

        // Stalled consumer, then a back-to-back request.
        issue(0, 32'h0000_00FF, mk(1'b1, 1'b0, 12'h0FF, 5'd1, 1), 1'b1);
        collect(0, 5);
        run(0, 32'h0000_AB00, mk(1'b1, 1'b0, 12'hCAB, 5'd13, 13));

        // Reset in the middle of a search.
        issue(0, 32'h0000_0101, mk(1'b0, 1'b0, 12'h000, 5'd16, 16), 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(out_valid[0]), 32'd0);
        check_eq("midrst_ready", 32'(in_ready[0]), 32'd0);
        check_out(0, mk(1'b0, 1'b0, 12'h000, 5'd0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid[0]) check_eq("ghost_valid", 32'(out_valid[0]), 32'd0);
        end
        check_eq("midrst_post_ready", 32'(in_ready[0]), 32'd1);
        run(0, 32'h0000_0000, mk(1'b1, 1'b0, 12'h000, 5'd1, 1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
